// File: rtl/psum_collector_if.sv
// ============================================================================
// Module   : psum_collector_if
// Brief    : Push/stall and valid/ready bundle between PE controller, collector
//            and downstream writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface psum_collector_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_FILT = 4,
    parameter int NUM_WIN  = 8
);
    localparam int c_FILT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int c_WIN_W  = (NUM_WIN  > 1) ? $clog2(NUM_WIN)  : 1;

    logic                done;
    logic [DATA_W-1:0]   psum_in;
    logic                stall;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [c_FILT_W-1:0] out_filt;
    logic [c_WIN_W-1:0]  out_win;
    logic                out_last;
    logic                overflow;

    modport master (
        output done, psum_in, out_ready,
        input  stall, out_valid, out_data, out_filt, out_win, out_last, overflow
    );

    modport slave (
        input  done, psum_in, out_ready,
        output stall, out_valid, out_data, out_filt, out_win, out_last, overflow
    );
endinterface

`default_nettype wire

// File: rtl/psum_collector.sv
// ============================================================================
// Module   : psum_collector
// Brief    : Tags PE partial sums with filter/window index and buffers them in
//            a FWFT FIFO. Optional ReLU at push when PSUM_RELU_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module psum_collector #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int NUM_FILT = 4,
    parameter int NUM_WIN  = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clear,
    psum_collector_if.slave   bus
);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_FILT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int c_WIN_W  = (NUM_WIN  > 1) ? $clog2(NUM_WIN)  : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_STALL = c_CNT_W'(DEPTH - 1);
    localparam logic [c_FILT_W-1:0] c_FILT_MAX  = c_FILT_W'(NUM_FILT - 1);
    localparam logic [c_WIN_W-1:0]  c_WIN_MAX   = c_WIN_W'(NUM_WIN - 1);

    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic                r_overflow;

    logic [DATA_W-1:0]   r_mem_data [DEPTH];
    logic [c_FILT_W-1:0] r_mem_filt [DEPTH];
    logic [c_WIN_W-1:0]  r_mem_win  [DEPTH];
    logic                r_mem_last [DEPTH];

    logic                w_full;
    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_filt_wrap;
    logic                w_last;
    logic [DATA_W-1:0]   w_wdata;

    assign w_full      = (r_count == c_CNT_FULL);
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid & bus.out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push      = bus.done & (~w_full | w_pop);
    assign w_filt_wrap = (r_filt_cnt == c_FILT_MAX);
    assign w_last      = w_filt_wrap & (r_win_cnt == c_WIN_MAX);

`ifdef PSUM_RELU_EN
    assign w_wdata = bus.psum_in[DATA_W-1] ? '0 : bus.psum_in;
`else
    assign w_wdata = bus.psum_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_filt_cnt <= '0;
            r_win_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_filt_cnt <= '0;
            r_win_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
                if (w_filt_wrap) begin
                    r_filt_cnt <= '0;
                    r_win_cnt  <= (r_win_cnt == c_WIN_MAX) ? '0 : r_win_cnt + c_WIN_W'(1);
                end else begin
                    r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.done && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_wdata;
            r_mem_filt[r_wptr] <= r_filt_cnt;
            r_mem_win[r_wptr]  <= r_win_cnt;
            r_mem_last[r_wptr] <= w_last;
        end
    end

    assign bus.stall     = (r_count >= c_CNT_STALL);
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? r_mem_data[r_rptr] : '0;
    assign bus.out_filt  = w_valid ? r_mem_filt[r_rptr] : '0;
    assign bus.out_win   = w_valid ? r_mem_win[r_rptr]  : '0;
    assign bus.out_last  = w_valid ? r_mem_last[r_rptr] : 1'b0;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_psum_collector.sv
// ============================================================================
// Module   : tb_psum_collector
// Brief    : Scoreboard bench for psum_collector: directed scenarios followed
//            by randomized push/pop/clear/reset traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_psum_collector;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 4;
    localparam int NUM_FILT = 4;
    localparam int NUM_WIN  = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                filt;
        int                win;
        bit                last;
    } exp_t;

    logic clk;
    logic rst;
    logic clear;

    psum_collector_if #(.DATA_W(DATA_W), .NUM_FILT(NUM_FILT), .NUM_WIN(NUM_WIN)) bus ();

    psum_collector #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_FILT (NUM_FILT),
        .NUM_WIN  (NUM_WIN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   n_acc   = 0;
    bit   exp_ovf = 1'b0;
    bit   mon_en  = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    function automatic logic [DATA_W-1:0] stored_value(logic [DATA_W-1:0] v);
`ifdef PSUM_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            check("stall",     32'(bus.stall),     32'(q.size() >= DEPTH - 1));
            check("overflow",  32'(bus.overflow),  32'(exp_ovf));
            if (q.size() != 0) begin
                check("out_data", 32'(bus.out_data), 32'(q[0].data));
                check("out_filt", 32'(bus.out_filt), q[0].filt);
                check("out_win",  32'(bus.out_win),  q[0].win);
                check("out_last", 32'(bus.out_last), 32'(q[0].last));
                if (bus.out_ready) void'(q.pop_front());
            end else begin
                check("empty_zero",
                      {13'd0, bus.out_last, bus.out_win, bus.out_filt, bus.out_data},
                      32'd0);
            end
        end
    end

    // Drives one cycle of stimulus and records the expected FIFO effect.
    task automatic step(bit d, logic [DATA_W-1:0] v, bit rdy, bit clr, bit rn);
        bit   pop;
        bit   full;
        bit   acc;
        exp_t e;
        bus.done      = d;
        bus.psum_in   = v;
        bus.out_ready = rdy;
        clear         = clr;
        rst           = rn;
        pop  = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        acc  = d && (!full || pop);
        @(posedge clk);
        #1;
        if (!rn || clr) begin
            q.delete();
            n_acc   = 0;
            exp_ovf = 1'b0;
        end else if (acc) begin
            e.data = stored_value(v);
            e.filt = n_acc % NUM_FILT;
            e.win  = (n_acc / NUM_FILT) % NUM_WIN;
            e.last = (e.filt == NUM_FILT - 1) && (e.win == NUM_WIN - 1);
            q.push_back(e);
            n_acc++;
        end else if (d) begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic idle(bit rdy, int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, 1'b1);
    endtask

    task automatic push(logic [DATA_W-1:0] v, bit rdy);
        step(1'b1, v, rdy, 1'b0, 1'b1);
    endtask

    initial begin
        bus.done      = 1'b0;
        bus.psum_in   = '0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
        rst           = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;

        // Single push with ready held high.
        idle(1'b1, 1);
        push(16'h0005, 1'b1);
        idle(1'b1, 2);

        // Full row sweep plus the first entry of the next row.
        for (int i = 0; i < NUM_FILT * NUM_WIN + 1; i++) push(16'($urandom), 1'b1);
        idle(1'b1, 2);

        // Back-pressure, overflow drop, and in-order drain.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i), 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 5);

        // Full FIFO with a push and a pop together.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i), 1'b0);
        push(16'h0300, 1'b1);
        idle(1'b0, 1);
        idle(1'b1, 5);

        // Negative input.
        push(16'hFFF0, 1'b0);
        idle(1'b1, 2);

        // Flush by clear, then by reset, each with entries queued.
        push(16'h0011, 1'b0);
        push(16'h0012, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        push(16'h0013, 1'b1);
        push(16'h0021, 1'b0);
        push(16'h0022, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        push(16'h0023, 1'b1);
        idle(1'b1, 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 149) != 0));
        end
        idle(1'b1, DEPTH + 2);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
